interval_timer_ctrl: RTL and testbench

- Controller that sequences a cascaded synchronous binary counter datapath as a programmable interval timer.
- The datapath is built from 4-bit counter stages with a ripple-enable AND carry chain.
- The controller owns the count-enable, clear and terminal-count compare, and provides start/stop/pause control.
- It produces one-shot or periodic tick events for downstream sequencing logic in the CH6 counter/register designs.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_count_stage.sv | 28 ++
 rtl/interval_timer_ctrl.sv | 147 ++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer controller and its counter stages.
package timer_pkg;

  localparam int STAGE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/timer_count_stage.sv
// One 4-bit synchronous counter stage; en_out forwards the ripple enable to the next stage.
module timer_count_stage
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en_in,
  input  logic               clr,
  output logic [STAGE_W-1:0] value,
  output logic               en_out
);

  // Stage value: clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= {STAGE_W{1'b0}};
    end else if (clr) begin
      value <= {STAGE_W{1'b0}};
    end else if (en_in) begin
      value <= value + {{(STAGE_W-1){1'b0}}, 1'b1};
    end else begin
      value <= value;
    end
  end

  assign en_out = en_in & (&value);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: FSM, terminal-count compare and cascaded 4-bit counter stages.
// Optional prescaler on the count enable is built when INTERVAL_TIMER_PRESCALE_EN is defined.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             tick,
  output logic             carry_out
);

  localparam int NSTAGE = WIDTH / STAGE_W;

  if ((WIDTH % STAGE_W) != 0 || WIDTH < STAGE_W) begin : g_bad_width
    $error("WIDTH must be a positive multiple of 4");
  end
  if (PRESCALE < 2 || PRESCALE > 16) begin : g_bad_prescale
    $error("PRESCALE must be in 2..16");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             en;
  logic             hit;
  logic             clr;
  logic             tick_nxt;
  logic [NSTAGE:0]  chain;

  assign hit = (count == limit_q);
  assign clr = stop | start | (en & hit);

`ifdef INTERVAL_TIMER_PRESCALE_EN
  localparam logic [4:0] PRE_LAST = 5'(PRESCALE - 1);

  logic [4:0] pre_cnt;
  logic       pre_strobe;

  assign pre_strobe = (pre_cnt == PRE_LAST);

  // Prescaler advances only in unpaused RUN and restarts with every start/stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= 5'd0;
    end else if (stop || start) begin
      pre_cnt <= 5'd0;
    end else if (state == RUN && !pause) begin
      pre_cnt <= pre_strobe ? 5'd0 : pre_cnt + 5'd1;
    end else begin
      pre_cnt <= pre_cnt;
    end
  end

  assign en = (state == RUN) & ~pause & pre_strobe;
`else
  assign en = (state == RUN) & ~pause;
`endif

  assign chain[0] = en;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    timer_count_stage u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_in  (chain[k]),
      .clr    (clr),
      .value  (count[k*STAGE_W +: STAGE_W]),
      .en_out (chain[k+1])
    );
  end

  assign carry_out = chain[NSTAGE];

  // Next state and tick: stop beats start, start beats pause and counting.
  always_comb begin
    state_nxt = state;
    tick_nxt  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_nxt = PAUSE;
          end else if (en && hit) begin
            tick_nxt  = 1'b1;
            state_nxt = periodic_q ? RUN : DONE;
          end else begin
            state_nxt = RUN;
          end
        end
        PAUSE: begin
          if (pause) begin
            state_nxt = PAUSE;
          end else begin
            state_nxt = RUN;
          end
        end
        IDLE:    state_nxt = IDLE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, latched configuration and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      limit_q    <= {WIDTH{1'b0}};
      periodic_q <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      paused     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick   <= tick_nxt;
      busy   <= (state_nxt == RUN) || (state_nxt == PAUSE);
      paused <= (state_nxt == PAUSE);
      done   <= (state_nxt == DONE);
      if (!stop && start) begin
        limit_q    <= limit;
        periodic_q <= periodic;
      end else begin
        limit_q    <= limit_q;
        periodic_q <= periodic_q;
      end
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: expected tick cycles are queued by the stimulus, a monitor pops them.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       periodic = 1'b0;
  logic [7:0] limit = 8'd0;
  logic [7:0] count;
  logic       busy, paused, done, tick, carry_out;

  int unsigned cyc = 0;
  int unsigned exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned s;

  interval_timer_ctrl #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .limit(limit), .count(count), .busy(busy),
    .paused(paused), .done(done), .tick(tick), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_neg(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Issue a one-cycle start from a negedge; returns at the negedge after the sampling edge.
  task automatic go_start(input logic [7:0] lim, input logic per, output int unsigned s_edge);
    limit    = lim;
    periodic = per;
    start    = 1'b1;
    s_edge   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Tick monitor: every observed tick must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        chk("tick_cycle", cyc, e);
        chk("tick_count_zero", {24'd0, count}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_paused", {31'd0, paused}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef INTERVAL_TIMER_PRESCALE_EN
    go_start(8'd1, 1'b1, s);
    exp_q.push_back(s + 8);
    exp_q.push_back(s + 16);
    exp_q.push_back(s + 24);
    at_neg(s + 24);
    chk("pre_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("pre_stop_busy", {31'd0, busy}, 32'd0);
`else
    // One-shot, limit 3
    go_start(8'd3, 1'b0, s);
    exp_q.push_back(s + 4);
    for (int k = 0; k < 4; k++) begin
      at_neg(s + k);
      chk("oneshot_count", {24'd0, count}, k);
      chk("oneshot_busy", {31'd0, busy}, 32'd1);
    end
    at_neg(s + 4);
    chk("oneshot_done", {31'd0, done}, 32'd1);
    chk("oneshot_notbusy", {31'd0, busy}, 32'd0);
    at_neg(s + 7);
    chk("oneshot_hold_count", {24'd0, count}, 32'd0);
    chk("oneshot_hold_done", {31'd0, done}, 32'd1);

    // Periodic, limit 2; a limit change mid-interval must be ignored
    go_start(8'd2, 1'b1, s);
    limit    = 8'd7;
    periodic = 1'b0;
    for (int k = 1; k <= 4; k++) exp_q.push_back(s + 3 * k);
    at_neg(s + 12);
    chk("periodic_busy", {31'd0, busy}, 32'd1);
    chk("periodic_done", {31'd0, done}, 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_count", {24'd0, count}, 32'd0);

    // Pause at count 4 for four sampled edges: tick moves from s+11 to s+16
    go_start(8'd10, 1'b0, s);
    exp_q.push_back(s + 16);
    at_neg(s + 4);
    chk("pause_pre_count", {24'd0, count}, 32'd4);
    pause = 1'b1;
    at_neg(s + 5);
    chk("pause_paused", {31'd0, paused}, 32'd1);
    chk("pause_hold", {24'd0, count}, 32'd4);
    at_neg(s + 8);
    chk("pause_hold_late", {24'd0, count}, 32'd4);
    chk("pause_busy", {31'd0, busy}, 32'd1);
    pause = 1'b0;
    at_neg(s + 10);
    chk("resume_count", {24'd0, count}, 32'd5);
    chk("resume_paused", {31'd0, paused}, 32'd0);
    at_neg(s + 15);
    chk("pause_final_count", {24'd0, count}, 32'd10);
    at_neg(s + 16);
    chk("pause_done", {31'd0, done}, 32'd1);

    // Asynchronous reset mid-count
    go_start(8'd10, 1'b0, s);
    at_neg(s + 5);
    chk("prereset_count", {24'd0, count}, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", {24'd0, count}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_flags", {29'd0, paused, done, tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // limit 0 periodic: tick every enabled cycle
    go_start(8'd0, 1'b1, s);
    exp_q.push_back(s + 1);
    exp_q.push_back(s + 2);
    exp_q.push_back(s + 3);
    at_neg(s + 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // start and stop together in RUN: stop wins
    go_start(8'd5, 1'b1, s);
    at_neg(s + 2);
    chk("prio_pre_count", {24'd0, count}, 32'd2);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("prio_busy", {31'd0, busy}, 32'd0);
    chk("prio_count", {24'd0, count}, 32'd0);

    // Full-range limit: carry_out at 0xFF coincides with the wrapping edge
    go_start(8'hFF, 1'b1, s);
    exp_q.push_back(s + 256);
    at_neg(s + 254);
    chk("carry_low", {31'd0, carry_out}, 32'd0);
    at_neg(s + 255);
    chk("carry_count_ff", {24'd0, count}, 32'hFF);
    chk("carry_high", {31'd0, carry_out}, 32'd1);
    at_neg(s + 256);
    chk("carry_wrap_count", {24'd0, count}, 32'd0);
    chk("carry_after", {31'd0, carry_out}, 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
`endif

    repeat (4) @(negedge clk);
    chk("tick_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
